// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers, with burst lock.
// Latency: 1 arbitration cycle in IDLE, then one beat per cycle combinationally onto the FIFO port.
// Backpressure: fifo_full drops the owner's req_ready the same cycle; optional counters under FIFO_ARB_STATS_EN.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       fifo_wr_en,
  output logic [WIDTH-1:0]           fifo_data_in,
  input  logic                       fifo_full,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
`ifdef FIFO_ARB_STATS_EN
  output logic [NUM_REQ*16-1:0]      grant_cnt,
`endif
  output logic                       busy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(MAX_BURST) + 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  logic [0:0]     state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] owner;
  logic [CW-1:0]  beat_cnt;

  logic [IDW-1:0] pick;
  logic [IDW-1:0] idx;
  logic           found;
  logic           beat;
  logic           burst_done;
  logic [IDW-1:0] owner_next;

  logic [WIDTH-1:0] data_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign data_arr[i]  = req_data[i*WIDTH +: WIDTH];
    assign req_ready[i] = (state == ST_BURST) && (owner == IDW'(i)) && !fifo_full;
  end

  // Scan starting at rr_ptr, wrapping explicitly since NUM_REQ need not be a power of 2.
  always_comb begin
    pick  = rr_ptr;
    found = 1'b0;
    idx   = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
      idx = (idx == IDW'(NUM_REQ - 1)) ? '0 : idx + IDW'(1);
    end
  end

  assign beat         = (state == ST_BURST) && req_valid[owner] && !fifo_full;
  assign burst_done   = req_last[owner] || (beat_cnt == CW'(MAX_BURST - 1));
  assign owner_next   = (owner == IDW'(NUM_REQ - 1)) ? '0 : owner + IDW'(1);
  assign fifo_wr_en   = beat;
  assign fifo_data_in = beat ? data_arr[owner] : '0;
  assign grant_id     = owner;
  assign busy         = (state == ST_BURST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            owner    <= pick;
            beat_cnt <= '0;
            state    <= ST_BURST;
          end
        end
        ST_BURST: begin
          // Without a beat the lock, owner and count are all held.
          if (beat) begin
            if (burst_done) begin
              beat_cnt <= '0;
              state    <= ST_IDLE;
              rr_ptr   <= owner_next;
            end else begin
              beat_cnt <= beat_cnt + CW'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stats
    logic [15:0] cnt;
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt <= '0;
      end else if (beat && (owner == IDW'(i)) && (cnt != 16'hFFFF)) begin
        cnt <= cnt + 16'd1;
      end
    end
    assign grant_cnt[i*16 +: 16] = cnt;
  end
`endif

endmodule
